// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester and register-file write-port bundle
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                     ALU_VALID;
    logic                     ALU_READY;
    logic [ADDR_WIDTH-1:0]    ALU_RD;
    logic [DATA_WIDTH-1:0]    ALU_DATA;
    logic                     LSU_VALID;
    logic                     LSU_READY;
    logic [ADDR_WIDTH-1:0]    LSU_RD;
    logic [DATA_WIDTH-1:0]    LSU_DATA;
    logic                     LOAD_ISSUE;
    logic [ADDR_WIDTH-1:0]    LOAD_ISSUE_RD;
    logic                     WEN;
    logic [ADDR_WIDTH-1:0]    RD_SEL;
    logic [DATA_WIDTH-1:0]    WB_DATA;
    logic [2**ADDR_WIDTH-1:0] BUSY;

    // Requesters, issue logic and RegFile side
    modport master (
        output ALU_VALID, ALU_RD, ALU_DATA,
        output LSU_VALID, LSU_RD, LSU_DATA,
        output LOAD_ISSUE, LOAD_ISSUE_RD,
        input  ALU_READY, LSU_READY,
        input  WEN, RD_SEL, WB_DATA, BUSY
    );

    // Arbiter side
    modport slave (
        input  ALU_VALID, ALU_RD, ALU_DATA,
        input  LSU_VALID, LSU_RD, LSU_DATA,
        input  LOAD_ISSUE, LOAD_ISSUE_RD,
        output ALU_READY, LSU_READY,
        output WEN, RD_SEL, WB_DATA, BUSY
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter with starvation guard and pending-load scoreboard
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic                 CLK,
    input logic                 RESET_N,
    regfile_wb_arbiter_if.slave bus
);
    localparam int         NREGS = 2**ADDR_WIDTH;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [NREGS-1:0]      busy_q, busy_d;

    logic starved;
    logic lsu_win;
    logic alu_win;

    // Grant: ALU has priority unless the LSU has waited STARVE_LIMIT cycles; nothing granted in reset
    always_comb begin
        starved = (starve_cnt_q == LIMIT);
        lsu_win = RESET_N & bus.LSU_VALID & (~bus.ALU_VALID | starved);
        alu_win = RESET_N & bus.ALU_VALID & ~lsu_win;
    end

    assign bus.ALU_READY = alu_win;
    assign bus.LSU_READY = lsu_win;

    // Starvation counter: count denied LSU cycles, saturate at the limit, clear otherwise
    always_comb begin
        starve_cnt_d = 4'd0;
        if (bus.LSU_VALID && !lsu_win) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    // Write port: capture the winner; x0 targets are accepted but never enable the write
    always_comb begin
        wen_d     = 1'b0;
        rd_sel_d  = rd_sel_q;
        wb_data_d = wb_data_q;
        if (lsu_win) begin
            wen_d     = (bus.LSU_RD != '0);
            rd_sel_d  = bus.LSU_RD;
            wb_data_d = bus.LSU_DATA;
        end else if (alu_win) begin
            wen_d     = (bus.ALU_RD != '0);
            rd_sel_d  = bus.ALU_RD;
            wb_data_d = bus.ALU_DATA;
        end
    end

    // Scoreboard: clear on load return, then set on issue so a same-index set wins
    always_comb begin
        busy_d = busy_q;
        if (lsu_win) begin
            busy_d[bus.LSU_RD] = 1'b0;
        end
        if (bus.LOAD_ISSUE && (bus.LOAD_ISSUE_RD != '0)) begin
            busy_d[bus.LOAD_ISSUE_RD] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; asynchronous reset drops any in-flight write and the scoreboard
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_cnt_q <= 4'd0;
            wen_q        <= 1'b0;
            rd_sel_q     <= '0;
            wb_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            rd_sel_q     <= rd_sel_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.WEN     = wen_q;
    assign bus.RD_SEL  = rd_sel_q;
    assign bus.WB_DATA = wb_data_q;
    assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic CLK = 1'b0;
    logic RESET_N;
    int   checks = 0;
    int   passed = 0;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    regfile_wb_arbiter #(
        .ADDR_WIDTH  (5),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(3)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    task automatic idle_inputs();
        bus.ALU_VALID     = 1'b0;
        bus.ALU_RD        = '0;
        bus.ALU_DATA      = '0;
        bus.LSU_VALID     = 1'b0;
        bus.LSU_RD        = '0;
        bus.LSU_DATA      = '0;
        bus.LOAD_ISSUE    = 1'b0;
        bus.LOAD_ISSUE_RD = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_N = 1'b0;
        bus.ALU_VALID = 1'b1;
        bus.LSU_VALID = 1'b1;
        #2;
        checks++; if ({bus.ALU_READY, bus.LSU_READY} !== 2'b00) $display("FAIL reset_ready_in_reset got=%b exp=00", {bus.ALU_READY, bus.LSU_READY}); else passed++;
        next_cycle();
        next_cycle();
        idle_inputs();
        RESET_N = 1'b1;
        next_cycle();
        checks++; if (bus.WEN !== 1'b0) $display("FAIL reset_wen got=%b exp=0", bus.WEN); else passed++;
        checks++; if (bus.RD_SEL !== 5'd0) $display("FAIL reset_rd_sel got=%0d exp=0", bus.RD_SEL); else passed++;
        checks++; if (bus.WB_DATA !== 32'h0) $display("FAIL reset_wb_data got=%h exp=0", bus.WB_DATA); else passed++;
        checks++; if (bus.BUSY !== 32'h0) $display("FAIL reset_busy got=%h exp=0", bus.BUSY); else passed++;
        checks++; if ({bus.ALU_READY, bus.LSU_READY} !== 2'b00) $display("FAIL reset_ready_idle got=%b exp=00", {bus.ALU_READY, bus.LSU_READY}); else passed++;
    endtask

    task automatic test_single_alu();
        bus.ALU_VALID = 1'b1;
        bus.ALU_RD    = 5'd5;
        bus.ALU_DATA  = 32'hDEADBEEF;
        @(negedge CLK);
        checks++; if ({bus.ALU_READY, bus.LSU_READY} !== 2'b10) $display("FAIL alu_ready got=%b exp=10", {bus.ALU_READY, bus.LSU_READY}); else passed++;
        next_cycle();
        idle_inputs();
        checks++; if (bus.WEN !== 1'b1) $display("FAIL alu_wen got=%b exp=1", bus.WEN); else passed++;
        checks++; if (bus.RD_SEL !== 5'd5) $display("FAIL alu_rd_sel got=%0d exp=5", bus.RD_SEL); else passed++;
        checks++; if (bus.WB_DATA !== 32'hDEADBEEF) $display("FAIL alu_wb_data got=%h exp=deadbeef", bus.WB_DATA); else passed++;
        next_cycle();
        checks++; if (bus.WEN !== 1'b0) $display("FAIL alu_wen_drop got=%b exp=0", bus.WEN); else passed++;
        checks++; if (bus.RD_SEL !== 5'd5) $display("FAIL alu_rd_sel_hold got=%0d exp=5", bus.RD_SEL); else passed++;
    endtask

    task automatic test_starvation();
        logic [4:0]  alu_rd_v [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd5};
        logic        lsu_v    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  rdy_v    [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        logic [4:0]  wr_rd_v  [6] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd5};
        logic [31:0] wr_dat_v [6] = '{32'h10, 32'h20, 32'h30, 32'h55, 32'h40, 32'h50};
        for (int c = 0; c < 6; c++) begin
            bus.ALU_VALID = 1'b1;
            bus.ALU_RD    = alu_rd_v[c];
            bus.ALU_DATA  = {23'd0, alu_rd_v[c], 4'd0};
            bus.LSU_VALID = lsu_v[c];
            bus.LSU_RD    = lsu_v[c] ? 5'd7 : 5'd0;
            bus.LSU_DATA  = lsu_v[c] ? 32'h55 : 32'h0;
            @(negedge CLK);
            checks++; if ({bus.ALU_READY, bus.LSU_READY} !== rdy_v[c]) $display("FAIL starve_ready c=%0d got=%b exp=%b", c, {bus.ALU_READY, bus.LSU_READY}, rdy_v[c]); else passed++;
            next_cycle();
            checks++; if ({bus.WEN, bus.RD_SEL, bus.WB_DATA} !== {1'b1, wr_rd_v[c], wr_dat_v[c]}) $display("FAIL starve_write c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, bus.WEN, bus.RD_SEL, bus.WB_DATA, wr_rd_v[c], wr_dat_v[c]); else passed++;
        end
        idle_inputs();
        checks++; if (dut.starve_cnt_q !== 4'd0) $display("FAIL starve_cnt_clear got=%0d exp=0", dut.starve_cnt_q); else passed++;
        next_cycle();
    endtask

    task automatic test_scoreboard();
        bus.LOAD_ISSUE = 1'b1; bus.LOAD_ISSUE_RD = 5'd9;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0000_0200) $display("FAIL sb_set got=%h exp=00000200", bus.BUSY); else passed++;
        bus.LSU_VALID = 1'b1; bus.LSU_RD = 5'd9; bus.LSU_DATA = 32'hAB;
        @(negedge CLK);
        checks++; if (bus.LSU_READY !== 1'b1) $display("FAIL sb_lsu_ready got=%b exp=1", bus.LSU_READY); else passed++;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0) $display("FAIL sb_clear got=%h exp=0", bus.BUSY); else passed++;
        bus.LOAD_ISSUE = 1'b1; bus.LOAD_ISSUE_RD = 5'd9;
        next_cycle();
        bus.LSU_VALID = 1'b1; bus.LSU_RD = 5'd9; bus.LSU_DATA = 32'hCD;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0000_0200) $display("FAIL sb_set_wins got=%h exp=00000200", bus.BUSY); else passed++;
        bus.LOAD_ISSUE = 1'b1; bus.LOAD_ISSUE_RD = 5'd12;
        bus.LSU_VALID = 1'b1; bus.LSU_RD = 5'd9; bus.LSU_DATA = 32'hEF;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0000_1000) $display("FAIL sb_diff_idx got=%h exp=00001000", bus.BUSY); else passed++;
        bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'd12; bus.ALU_DATA = 32'h99;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0000_1000) $display("FAIL sb_alu_no_touch got=%h exp=00001000", bus.BUSY); else passed++;
        bus.LSU_VALID = 1'b1; bus.LSU_RD = 5'd12; bus.LSU_DATA = 32'h1;
        next_cycle();
        idle_inputs();
        bus.LOAD_ISSUE = 1'b1; bus.LOAD_ISSUE_RD = 5'd0;
        next_cycle();
        idle_inputs();
        checks++; if (bus.BUSY !== 32'h0) $display("FAIL sb_x0_issue got=%h exp=0", bus.BUSY); else passed++;
    endtask

    task automatic test_x0_write();
        bus.LSU_VALID = 1'b1; bus.LSU_RD = 5'd0; bus.LSU_DATA = 32'h1234;
        @(negedge CLK);
        checks++; if ({bus.ALU_READY, bus.LSU_READY} !== 2'b01) $display("FAIL x0_ready got=%b exp=01", {bus.ALU_READY, bus.LSU_READY}); else passed++;
        next_cycle();
        idle_inputs();
        checks++; if (bus.WEN !== 1'b0) $display("FAIL x0_wen got=%b exp=0", bus.WEN); else passed++;
        checks++; if (bus.WB_DATA !== 32'h1234) $display("FAIL x0_wb_data got=%h exp=00001234", bus.WB_DATA); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.LOAD_ISSUE = 1'b1; bus.LOAD_ISSUE_RD = 5'd4;
        bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'd6; bus.ALU_DATA = 32'h66;
        next_cycle();
        idle_inputs();
        checks++; if ({bus.WEN, bus.BUSY} !== {1'b1, 32'h0000_0010}) $display("FAIL mid_inflight got=%b/%h exp=1/00000010", bus.WEN, bus.BUSY); else passed++;
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (bus.WEN !== 1'b0) $display("FAIL mid_wen got=%b exp=0", bus.WEN); else passed++;
        checks++; if (bus.BUSY !== 32'h0) $display("FAIL mid_busy got=%h exp=0", bus.BUSY); else passed++;
        next_cycle();
        RESET_N = 1'b1;
        bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'd6; bus.ALU_DATA = 32'h77;
        @(negedge CLK);
        checks++; if (bus.ALU_READY !== 1'b1) $display("FAIL mid_alu_ready got=%b exp=1", bus.ALU_READY); else passed++;
        next_cycle();
        idle_inputs();
        checks++; if ({bus.WEN, bus.RD_SEL, bus.WB_DATA} !== {1'b1, 5'd6, 32'h77}) $display("FAIL mid_write got=%b/%0d/%h exp=1/6/00000077", bus.WEN, bus.RD_SEL, bus.WB_DATA); else passed++;
        next_cycle();
        checks++; if (bus.WEN !== 1'b0) $display("FAIL mid_wen_drop got=%b exp=0", bus.WEN); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_starvation();
        test_scoreboard();
        test_x0_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WEN / RD_SEL / WB_DATA) between two writeback requesters: the ALU pipe and the load/store unit (LSU).
- ALU has fixed priority. A starvation counter guarantees LSU progress.
- Also keeps a pending-load scoreboard, so issue logic can stall on registers whose load data has not yet returned.
- Sits between the execute/memory stages and RegFile; its registered outputs drive RegFile write inputs directly.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, writeback data width.
- STARVE_LIMIT, 3, consecutive cycles LSU may be denied before it is forced to win (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ALU_VALID  in  1  ALU writeback request.
- ALU_READY  out  1  ALU request granted this cycle (combinational).
- ALU_RD  in  ADDR_WIDTH  ALU destination register.
- ALU_DATA  in  DATA_WIDTH  ALU result.
- LSU_VALID  in  1  load-return writeback request.
- LSU_READY  out  1  LSU request granted this cycle (combinational).
- LSU_RD  in  ADDR_WIDTH  load destination register.
- LSU_DATA  in  DATA_WIDTH  load data.
- LOAD_ISSUE  in  1  a load is issued this cycle.
- LOAD_ISSUE_RD  in  ADDR_WIDTH  destination register of the issued load.
- WEN  out  1  registered write enable to RegFile.
- RD_SEL  out  ADDR_WIDTH  registered write index.
- WB_DATA  out  DATA_WIDTH  registered write data.
- BUSY  out  2**ADDR_WIDTH  pending-load bitmap; bit 0 is always 0.

Behaviour:
- Reset (async assert, sync release): WEN=0, RD_SEL=0, WB_DATA=0, BUSY=0, starve_cnt=0. While RESET_N=0, ALU_READY=LSU_READY=0.
- Grant (combinational, same cycle):
  - lsu_win = LSU_VALID & (!ALU_VALID | starve_cnt==STARVE_LIMIT).
  - alu_win = ALU_VALID & !lsu_win.
  - ALU_READY=alu_win, LSU_READY=lsu_win. At most one is high.
- Handshake:
  - Transfer occurs when VALID & READY.
  - A requester that is denied holds VALID, RD and DATA stable until granted. The block does not check this.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when LSU_VALID & !lsu_win.
  - Clears to 0 when lsu_win or !LSU_VALID.
  - When starve_cnt==STARVE_LIMIT and both are valid, LSU wins and ALU_READY=0 that cycle.
- Write port (1-cycle latency; transfer in cycle N appears on outputs in cycle N+1):
  - On a granted transfer: RD_SEL<=winner RD, WB_DATA<=winner DATA, WEN<=(winner RD != 0).
  - No transfer: WEN<=0; RD_SEL and WB_DATA hold their previous values.
  - Writes to x0 are accepted (READY asserted) but produce WEN=0.
- Scoreboard:
  - BUSY[LOAD_ISSUE_RD] is set on LOAD_ISSUE when LOAD_ISSUE_RD != 0.
  - BUSY[LSU_RD] is cleared on an LSU transfer.
  - Set and clear of the same index in the same cycle: set wins.
  - Issue and clear of different indices in the same cycle are both applied.
  - ALU transfers never touch BUSY.
  - BUSY[0] is constant 0.
- Reset mid-operation: any pending grant is discarded, a registered write in flight is dropped (WEN=0 immediately), and BUSY is cleared.
- No combinational path from any input to WEN, RD_SEL, WB_DATA or BUSY.

Test Plan:
1. Reset then idle: RESET_N=0 for 2 cycles, release, no requests -> WEN=0, RD_SEL=0, WB_DATA=0, BUSY=0, both READY=0.
2. Single ALU write: ALU_VALID=1, ALU_RD=5, ALU_DATA=0xDEADBEEF for 1 cycle -> ALU_READY=1 same cycle; next cycle WEN=1, RD_SEL=5, WB_DATA=0xDEADBEEF; following cycle WEN=0.
3. Contention and starvation (STARVE_LIMIT=3): ALU_VALID=1 every cycle with rd=1,2,3,4,5; LSU_VALID=1 rd=7 data=0x55 held -> ALU granted cycles 0-2, LSU granted cycle 3 (ALU_READY=0); WEN sequence writes rd 1,2,3,7,4 on consecutive cycles; starve_cnt returns to 0.
4. Scoreboard: LOAD_ISSUE rd=9 -> BUSY[9]=1 next cycle; LSU transfer rd=9 -> BUSY[9]=0 next cycle. Same-cycle LOAD_ISSUE rd=9 with LSU transfer rd=9 -> BUSY[9] stays 1. LOAD_ISSUE rd=0 -> BUSY=0.
5. x0 writes: LSU transfer rd=0 data=0x1234 -> LSU_READY=1, next cycle WEN=0.
6. Reset mid-operation: BUSY[4]=1 and ALU transfer rd=6 in flight; assert RESET_N low between edges -> WEN=0 and BUSY=0 immediately; after release, ALU write rd=6 data=0x77 completes normally with 1-cycle latency.
